// File: rtl/reg_file_param.sv
// Parametrised register file: two write ports (port 2 has priority), two registered
// read ports, synchronous clear, optional hardwired-zero entry 0 and write-to-read bypass.
module reg_file_param #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                ZERO_REG  = 1'b0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write_en1,
  input  logic [ADDR_W-1:0] write_addr1,
  input  logic [WIDTH-1:0]  write_data1,
  input  logic              write_en2,
  input  logic [ADDR_W-1:0] write_addr2,
  input  logic [WIDTH-1:0]  write_data2,
  input  logic              read_en1,
  input  logic [ADDR_W-1:0] read_addr1,
  output logic [WIDTH-1:0]  read_data1,
  output logic              read_valid1,
  input  logic              read_en2,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [WIDTH-1:0]  read_data2,
  output logic              read_valid2
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic             rd_valid1_q, rd_valid2_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Addresses that hold real storage: in range and not the hardwired-zero entry.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = RESET_VAL;
    end else begin
      if (write_en1 && live(write_addr1)) mem_d[write_addr1] = write_data1;
      if (write_en2 && live(write_addr2)) mem_d[write_addr2] = write_data2;
    end
  end

  // Read next-value priority mirrors the write path: clear, then port 2, then port 1.
  always_comb begin
    rd_data1_d = '0;
    if (live(read_addr1)) begin
      if (clear)                                              rd_data1_d = RESET_VAL;
      else if (BYPASS && write_en2 && write_addr2 == read_addr1) rd_data1_d = write_data2;
      else if (BYPASS && write_en1 && write_addr1 == read_addr1) rd_data1_d = write_data1;
      else                                                    rd_data1_d = mem_q[read_addr1];
    end
  end

  always_comb begin
    rd_data2_d = '0;
    if (live(read_addr2)) begin
      if (clear)                                              rd_data2_d = RESET_VAL;
      else if (BYPASS && write_en2 && write_addr2 == read_addr2) rd_data2_d = write_data2;
      else if (BYPASS && write_en1 && write_addr1 == read_addr2) rd_data2_d = write_data1;
      else                                                    rd_data2_d = mem_q[read_addr2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      rd_data1_q  <= '0;
      rd_data2_q  <= '0;
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_valid1_q <= read_en1;
      rd_valid2_q <= read_en2;
      if (read_en1) rd_data1_q <= rd_data1_d;
      if (read_en2) rd_data2_q <= rd_data2_d;
    end
  end

  assign read_data1  = rd_data1_q;
  assign read_data2  = rd_data2_q;
  assign read_valid1 = rd_valid1_q;
  assign read_valid2 = rd_valid2_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param across four parameter builds; each phase
// resets everything and reads only from the selected build.
module tb_reg_file_param;

  logic       clk, rst, clear;
  logic       we1, we2, re1, re2;
  logic [2:0] wa1, wa2, ra1, ra2;
  logic [7:0] wd1, wd2;
  logic [1:0] sel;
  logic [3:0] re1_g, re2_g;
  logic [7:0] rdd [8];
  logic       rdv [8];
  logic [7:0] exp_q [8][$];
  int         checks, errors;

  assign re1_g = {4{re1}} & (4'b0001 << sel);
  assign re2_g = {4{re2}} & (4'b0001 << sel);

  reg_file_param u_def (
    .clk(clk), .rst(rst), .clear(clear),
    .write_en1(we1), .write_addr1(wa1[1:0]), .write_data1(wd1),
    .write_en2(we2), .write_addr2(wa2[1:0]), .write_data2(wd2),
    .read_en1(re1_g[0]), .read_addr1(ra1[1:0]), .read_data1(rdd[0]), .read_valid1(rdv[0]),
    .read_en2(re2_g[0]), .read_addr2(ra2[1:0]), .read_data2(rdd[1]), .read_valid2(rdv[1]));

  reg_file_param #(.RESET_VAL(8'h5A), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .clear(clear),
    .write_en1(we1), .write_addr1(wa1[1:0]), .write_data1(wd1),
    .write_en2(we2), .write_addr2(wa2[1:0]), .write_data2(wd2),
    .read_en1(re1_g[1]), .read_addr1(ra1[1:0]), .read_data1(rdd[2]), .read_valid1(rdv[2]),
    .read_en2(re2_g[1]), .read_addr2(ra2[1:0]), .read_data2(rdd[3]), .read_valid2(rdv[3]));

  reg_file_param #(.ZERO_REG(1'b1)) u_zero (
    .clk(clk), .rst(rst), .clear(clear),
    .write_en1(we1), .write_addr1(wa1[1:0]), .write_data1(wd1),
    .write_en2(we2), .write_addr2(wa2[1:0]), .write_data2(wd2),
    .read_en1(re1_g[2]), .read_addr1(ra1[1:0]), .read_data1(rdd[4]), .read_valid1(rdv[4]),
    .read_en2(re2_g[2]), .read_addr2(ra2[1:0]), .read_data2(rdd[5]), .read_valid2(rdv[5]));

  reg_file_param #(.DEPTH(5), .ADDR_W(3)) u_d5 (
    .clk(clk), .rst(rst), .clear(clear),
    .write_en1(we1), .write_addr1(wa1), .write_data1(wd1),
    .write_en2(we2), .write_addr2(wa2), .write_data2(wd2),
    .read_en1(re1_g[3]), .read_addr1(ra1), .read_data1(rdd[6]), .read_valid1(rdv[6]),
    .read_en2(re2_g[3]), .read_addr2(ra2), .read_data2(rdd[7]), .read_valid2(rdv[7]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every valid pulse pops the oldest expected value for that port.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 8; i++) begin
      if (rdv[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid port%0d: got data %h, required no valid", i, rdd[i]);
        end else begin
          logic [7:0] e;
          e = exp_q[i].pop_front();
          if (rdd[i] !== e) begin
            errors++;
            $display("FAIL read_data port%0d: got %h, required %h", i, rdd[i], e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic idle();
    clear = 1'b0; we1 = 1'b0; we2 = 1'b0; re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic wr1(input logic [2:0] a, input logic [7:0] d);
    we1 = 1'b1; wa1 = a; wd1 = d;
  endtask

  task automatic wr2(input logic [2:0] a, input logic [7:0] d);
    we2 = 1'b1; wa2 = a; wd2 = d;
  endtask

  task automatic rd1(input logic [2:0] a, input logic [7:0] e);
    re1 = 1'b1; ra1 = a;
    exp_q[2*int'(sel)].push_back(e);
  endtask

  task automatic rd2(input logic [2:0] a, input logic [7:0] e);
    re2 = 1'b1; ra2 = a;
    exp_q[2*int'(sel)+1].push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; sel = 2'd0;
    wa1 = '0; wa2 = '0; ra1 = '0; ra2 = '0; wd1 = '0; wd2 = '0;
    idle();
    @(negedge clk);
    check("reset_data1", 32'(rdd[0]), 32'h0);
    check("reset_valid1", 32'(rdv[0]), 32'h0);
    rst = 1'b0;

    // Default build: basic writes/reads, hold, collision, bypass, clear, mid-run reset
    wr1(0, 8'hAA); wr2(1, 8'hCC); step();
    rd1(0, 8'hAA); rd2(1, 8'hCC); step();
    step();
    check("hold_data1", 32'(rdd[0]), 32'hAA);
    check("hold_data2", 32'(rdd[1]), 32'hCC);
    check("idle_valid1", 32'(rdv[0]), 32'h0);
    check("idle_valid2", 32'(rdv[1]), 32'h0);
    wr1(2, 8'h11); wr2(2, 8'h22); step();
    rd1(2, 8'h22); step();
    wr1(1, 8'h01); rd1(1, 8'h01); rd2(1, 8'h01); step();
    wr1(3, 8'h33); wr2(3, 8'h44); rd1(3, 8'h44); step();
    clear = 1'b1; wr1(2, 8'hF0); rd2(2, 8'h00); step();
    rd1(2, 8'h00); rd2(0, 8'h00); step();
    wr1(1, 8'h77); step();
    rd1(1, 8'h77); step();
    re1 = 1'b1; ra1 = 3'd1;
    #2 rst = 1'b1;
    #1;
    check("midrst_data1", 32'(rdd[0]), 32'h0);
    check("midrst_data2", 32'(rdd[1]), 32'h0);
    check("midrst_valid1", 32'(rdv[0]), 32'h0);
    step();
    check("midrst_held_valid1", 32'(rdv[0]), 32'h0);
    rst = 1'b0;
    rd1(0, 8'h00); rd2(1, 8'h00); step();
    rd1(2, 8'h00); rd2(3, 8'h00); step();
    step();

    // No-bypass build with RESET_VAL 0x5A
    sel = 2'd1; do_reset();
    rd1(0, 8'h5A); rd2(3, 8'h5A); step();
    wr2(1, 8'hCC); step();
    wr1(1, 8'h01); rd1(1, 8'hCC); step();
    rd1(1, 8'h01); step();
    clear = 1'b1; wr2(2, 8'hF0); rd2(1, 8'h5A); step();
    rd1(2, 8'h5A); rd2(1, 8'h5A); step();
    step();

    // Hardwired-zero entry 0
    sel = 2'd2; do_reset();
    wr1(0, 8'h55); wr2(1, 8'h66); step();
    rd1(0, 8'h00); rd2(1, 8'h66); step();
    wr2(0, 8'h77); rd1(0, 8'h00); step();
    step();

    // Non-power-of-2 depth with out-of-range addresses
    sel = 2'd3; do_reset();
    wr1(0, 8'hA0); wr2(1, 8'hA1); step();
    wr1(2, 8'hA2); wr2(3, 8'hA3); step();
    wr1(4, 8'hA4); step();
    wr1(6, 8'hEE); wr2(5, 8'hDD); step();
    rd1(6, 8'h00); rd2(4, 8'hA4); step();
    wr1(6, 8'hEE); rd1(6, 8'h00); rd2(7, 8'h00); step();
    rd1(0, 8'hA0); rd2(1, 8'hA1); step();
    rd1(2, 8'hA2); rd2(3, 8'hA3); step();
    rd1(4, 8'hA4); rd2(5, 8'h00); step();

    repeat (3) step();
    for (int i = 0; i < 8; i++) check($sformatf("pending_port%0d", i), exp_q[i].size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
